// File: rtl/modulo_controlador_sensores_contador_if.sv
// Bundle of sensor, preset and counter-side signals between the control stage and its environment.
// slave = the control stage itself, master = whoever drives sensors, preset and q.
interface modulo_controlador_sensores_contador_if;
   logic       sensor_a;
   logic       sensor_b;
   logic       preset_req;
   logic [4:0] preset_val;
   logic [4:0] q;
   logic       up_down;
   logic       enable;
   logic       load;
   logic [4:0] e_load;
   logic       full;
   logic       empty;
   logic       reject;
   logic       error;

   modport slave (
      input  sensor_a, sensor_b, preset_req, preset_val, q,
      output up_down, enable, load, e_load, full, empty, reject, error
   );

   modport master (
      output sensor_a, sensor_b, preset_req, preset_val, q,
      input  up_down, enable, load, e_load, full, empty, reject, error
   );
endinterface

// File: rtl/modulo_controlador_sensores_contador.sv
// Turns two debounced beam sensors into one-cycle up/down count strobes and preset loads.
// Strobes appear one cycle after the final filtered transition; a preset load wins over a same-cycle event.
module modulo_controlador_sensores_contador #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CAPACITY        = 31
) (
   input logic clk,
   input logic rst_n,
   modulo_controlador_sensores_contador_if.slave bus
);

   localparam logic [4:0] CAP     = 5'(CAPACITY);
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, E_A, E_AB, E_B, X_B, X_BA, X_A, ERR
   } state_t;

   logic [1:0]      sync_a;
   logic [1:0]      sync_b;
   logic [1:0]      raw_s;
   logic [1:0]      fab;
   logic [1:0][3:0] db_cnt;

   state_t state;
   state_t next_state;
   logic   entry_evt;
   logic   exit_evt;
   logic   err_lvl;

   logic       preset_q;
   logic       preset_rise;
   logic       is_full;
   logic       is_empty;
   logic       ok_up;
   logic       ok_dn;
   logic       rej_now;
   logic       up_down_r;
   logic       enable_r;
   logic       load_r;
   logic [4:0] e_load_r;
   logic       reject_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= {sync_a[0], bus.sensor_a};
         sync_b <= {sync_b[0], bus.sensor_b};
      end
   end

   // bit 1 = outer beam A, bit 0 = inner beam B
   assign raw_s = {sync_a[1], sync_b[1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fab    <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (raw_s[i] == fab[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               fab[i]    <= raw_s[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = ERR;
      case (state)
         IDLE: case (fab)
            2'b00:   next_state = IDLE;
            2'b10:   next_state = E_A;
            2'b01:   next_state = X_B;
            default: next_state = ERR;
         endcase
         E_A: case (fab)
            2'b10:   next_state = E_A;
            2'b11:   next_state = E_AB;
            2'b00:   next_state = IDLE;
            default: next_state = ERR;
         endcase
         E_AB: case (fab)
            2'b11:   next_state = E_AB;
            2'b01:   next_state = E_B;
            2'b10:   next_state = E_A;
            default: next_state = ERR;
         endcase
         E_B: case (fab)
            2'b01:   next_state = E_B;
            2'b00:   next_state = IDLE;
            2'b11:   next_state = E_AB;
            default: next_state = ERR;
         endcase
         X_B: case (fab)
            2'b01:   next_state = X_B;
            2'b11:   next_state = X_BA;
            2'b00:   next_state = IDLE;
            default: next_state = ERR;
         endcase
         X_BA: case (fab)
            2'b11:   next_state = X_BA;
            2'b10:   next_state = X_A;
            2'b01:   next_state = X_B;
            default: next_state = ERR;
         endcase
         X_A: case (fab)
            2'b10:   next_state = X_A;
            2'b00:   next_state = IDLE;
            2'b11:   next_state = X_BA;
            default: next_state = ERR;
         endcase
         ERR:     next_state = (fab == 2'b00) ? IDLE : ERR;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      entry_evt = (state == E_B) && (fab == 2'b00);
      exit_evt  = (state == X_A) && (fab == 2'b00);
      err_lvl   = (state == ERR);
   end

   assign preset_rise = bus.preset_req && !preset_q;
   assign is_full     = (bus.q == CAP);
   assign is_empty    = (bus.q == 5'd0);
   assign ok_up       = entry_evt && !is_full;
   assign ok_dn       = exit_evt && !is_empty;
   assign rej_now     = (entry_evt && is_full) || (exit_evt && is_empty);

   // A maturing event is dropped when the load strobe goes out in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preset_q  <= 1'b0;
         up_down_r <= 1'b1;
         enable_r  <= 1'b0;
         load_r    <= 1'b0;
         e_load_r  <= '0;
         reject_r  <= 1'b0;
      end else begin
         preset_q <= bus.preset_req;
         load_r   <= preset_rise;
         enable_r <= (ok_up || ok_dn) && !preset_rise;
         reject_r <= rej_now && !preset_rise;
         if ((ok_up || ok_dn) && !preset_rise) up_down_r <= ok_up;
         if (preset_rise) e_load_r <= (bus.preset_val > CAP) ? CAP : bus.preset_val;
      end
   end

   assign bus.up_down = up_down_r;
   assign bus.enable  = enable_r;
   assign bus.load    = load_r;
   assign bus.e_load  = e_load_r;
   assign bus.reject  = reject_r;
   assign bus.error   = err_lvl;
   assign bus.full    = is_full;
   assign bus.empty   = is_empty;

endmodule

// File: tb/tb_modulo_controlador_sensores_contador.sv
// Directed bench: table of whole sensor passages plus hand sequences for latency, glitches, presets and reset.
module tb_modulo_controlador_sensores_contador;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   modulo_controlador_sensores_contador_if bus ();
   modulo_controlador_sensores_contador_if bus25 ();

   assign bus25.sensor_a   = bus.sensor_a;
   assign bus25.sensor_b   = bus.sensor_b;
   assign bus25.preset_req = bus.preset_req;
   assign bus25.preset_val = bus.preset_val;
   assign bus25.q          = bus.q;

   modulo_controlador_sensores_contador #(.DEBOUNCE_CYCLES(4), .CAPACITY(31)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   modulo_controlador_sensores_contador #(.DEBOUNCE_CYCLES(4), .CAPACITY(25)) dut25 (
      .clk(clk), .rst_n(rst_n), .bus(bus25)
   );

   typedef struct {
      logic [4:0]  q;
      int          n;
      logic [11:0] steps;
      int          en;
      int          dir;
      int          rej;
      int          err;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   int   en_cnt, rej_cnt, err_seen, viol;
   logic prev_en = 1'b0;
   vec_t vecs [13];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.enable) en_cnt++;
      if (bus.reject) rej_cnt++;
      if (bus.error) err_seen = 1;
      if (bus.enable && (prev_en || bus.load)) viol++;
      prev_en = bus.enable;
   endtask

   task automatic hold(input logic [1:0] s, input int n);
      bus.sensor_a = s[1];
      bus.sensor_b = s[0];
      repeat (n) tick();
   endtask

   task automatic clear_counts();
      en_cnt = 0;
      rej_cnt = 0;
      err_seen = 0;
   endtask

   function automatic vec_t mk(input logic [4:0] q, input int n, input logic [11:0] s,
                               input int en, input int dir, input int rej, input int err);
      vec_t v;
      v.q = q; v.n = n; v.steps = s; v.en = en; v.dir = dir; v.rej = rej; v.err = err;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(5'd5,  4, 12'b10_11_01_00_00_00, 1,  1, 0, 0);
      vecs[1]  = mk(5'd5,  4, 12'b01_11_10_00_00_00, 1,  0, 0, 0);
      vecs[2]  = mk(5'd31, 4, 12'b10_11_01_00_00_00, 0, -1, 1, 0);
      vecs[3]  = mk(5'd0,  4, 12'b01_11_10_00_00_00, 0, -1, 1, 0);
      vecs[4]  = mk(5'd5,  2, 12'b10_00_00_00_00_00, 0, -1, 0, 0);
      vecs[5]  = mk(5'd5,  2, 12'b01_00_00_00_00_00, 0, -1, 0, 0);
      vecs[6]  = mk(5'd5,  2, 12'b11_00_00_00_00_00, 0, -1, 0, 1);
      vecs[7]  = mk(5'd5,  4, 12'b10_11_01_00_00_00, 1,  1, 0, 0);
      vecs[8]  = mk(5'd5,  6, 12'b10_11_10_11_01_00, 1,  1, 0, 0);
      vecs[9]  = mk(5'd0,  4, 12'b10_11_01_00_00_00, 1,  1, 0, 0);
      vecs[10] = mk(5'd31, 4, 12'b01_11_10_00_00_00, 1,  0, 0, 0);
      vecs[11] = mk(5'd5,  3, 12'b10_01_00_00_00_00, 0, -1, 0, 1);
      vecs[12] = mk(5'd5,  6, 12'b01_11_01_11_10_00, 1,  0, 0, 0);

      viol = 0;
      clear_counts();
      bus.sensor_a = 1'b0;
      bus.sensor_b = 1'b0;
      bus.preset_req = 1'b0;
      bus.preset_val = 5'd0;
      bus.q = 5'd0;

      // reset held while the sensors toggle
      for (int i = 0; i < 8; i++) hold(2'(i), 1);
      check("rst_up_down", int'(bus.up_down), 1);
      check("rst_enable", en_cnt, 0);
      check("rst_load", int'(bus.load), 0);
      check("rst_e_load", int'(bus.e_load), 0);
      check("rst_error", err_seen, 0);
      rst_n = 1'b1;
      hold(2'b00, 10);
      check("rst_empty", int'(bus.empty), 1);
      check("rst_full", int'(bus.full), 0);

      // enable appears exactly 7 cycles after the raw 00 (2 sync + 4 debounce + 1)
      bus.q = 5'd5;
      clear_counts();
      hold(2'b10, 10);
      hold(2'b11, 10);
      hold(2'b01, 10);
      bus.sensor_a = 1'b0;
      bus.sensor_b = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i >= 6 && i <= 8) check($sformatf("lat_enable_t%0d", i), int'(bus.enable), (i == 7) ? 1 : 0);
         if (i == 7) check("lat_up_down", int'(bus.up_down), 1);
      end
      check("lat_count", en_cnt, 1);

      for (int v = 0; v < 13; v++) begin
         bus.q = vecs[v].q;
         clear_counts();
         for (int k = 0; k < vecs[v].n; k++) hold(vecs[v].steps[11 - 2*k -: 2], 10);
         check($sformatf("vec%0d_enable", v), en_cnt, vecs[v].en);
         check($sformatf("vec%0d_reject", v), rej_cnt, vecs[v].rej);
         check($sformatf("vec%0d_err_seen", v), err_seen, vecs[v].err);
         check($sformatf("vec%0d_err_end", v), int'(bus.error), 0);
         check($sformatf("vec%0d_full", v), int'(bus.full), (vecs[v].q == 5'd31) ? 1 : 0);
         check($sformatf("vec%0d_empty", v), int'(bus.empty), (vecs[v].q == 5'd0) ? 1 : 0);
         if (vecs[v].dir >= 0) check($sformatf("vec%0d_up_down", v), int'(bus.up_down), vecs[v].dir);
      end

      // short glitches must not move the FSM out of IDLE
      bus.q = 5'd5;
      clear_counts();
      hold(2'b01, 2);
      hold(2'b00, 3);
      hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
      check("glitch_b_enable", en_cnt, 1);
      check("glitch_b_error", err_seen, 0);
      clear_counts();
      hold(2'b10, 2);
      hold(2'b00, 3);
      hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
      check("glitch_a_enable", en_cnt, 1);
      check("glitch_a_error", err_seen, 0);
      check("glitch_a_up_down", int'(bus.up_down), 0);

      // preset edge detection and clamping
      bus.preset_val = 5'd20;
      bus.preset_req = 1'b1;
      tick();
      check("preset_load_t1", int'(bus.load), 1);
      check("preset_e_load", int'(bus.e_load), 20);
      tick();
      check("preset_load_t2", int'(bus.load), 0);
      check("preset_e_load_hold", int'(bus.e_load), 20);
      bus.preset_req = 1'b0;
      tick();
      bus.preset_val = 5'd31;
      bus.preset_req = 1'b1;
      tick();
      check("clamp25_e_load", int'(bus25.e_load), 25);
      check("clamp31_e_load", int'(bus.e_load), 31);
      bus.preset_req = 1'b0;
      bus.q = 5'd25;
      tick();
      check("cap25_full", int'(bus25.full), 1);
      check("cap31_full", int'(bus.full), 0);

      // entry maturing in the load cycle is discarded
      bus.q = 5'd5;
      bus.preset_val = 5'd7;
      clear_counts();
      hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
      bus.sensor_a = 1'b0;
      bus.sensor_b = 1'b0;
      repeat (6) tick();
      bus.preset_req = 1'b1;
      tick();
      check("collide_load", int'(bus.load), 1);
      check("collide_enable", int'(bus.enable), 0);
      bus.preset_req = 1'b0;
      repeat (3) tick();
      check("collide_en_count", en_cnt, 0);
      check("collide_reject", rej_cnt, 0);
      check("collide_e_load", int'(bus.e_load), 7);

      // reset in E_AB discards the partial passage
      clear_counts();
      hold(2'b10, 10);
      hold(2'b11, 10);
      bus.sensor_a = 1'b0;
      bus.sensor_b = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      hold(2'b01, 10);
      hold(2'b00, 10);
      check("midrst_enable", en_cnt, 0);
      check("midrst_error", err_seen, 0);
      hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
      check("midrst_fresh_enable", en_cnt, 1);

      check("enable_spacing_and_overlap", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
